// File: rtl/adder_result_accum.sv
// rtl/adder_result_accum.sv - sums COUNT_MAX carry-select adder results per block, valid/ready in and out
// Optional build macro: ADDER_RESULT_ACCUM_SATURATE_EN (clamp accumulator on overflow instead of wrapping)
module adder_result_accum #(
  parameter int IN_W      = 17,
  parameter int ACC_W     = 32,
  parameter int COUNT_MAX = 16,
  localparam int CNT_W    = $clog2(COUNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_cout,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_total;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_overflow;

  logic [ACC_W-1:0]   w_operand;
  logic [ACC_W:0]     w_sum_ext;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_ovf_next;
  logic               w_accept;
  logic               w_last;

  // The adder result is {cout, sum}; zero-extend it to the accumulator width.
  assign w_operand = ACC_W'({in_cout, in_sum});
  assign w_sum_ext = {1'b0, r_acc} + {1'b0, w_operand};
  assign w_carry   = w_sum_ext[ACC_W];

  // Next accumulator value: wrap by default, clamp to all-ones when saturating.
  always_comb begin
    w_acc_next = w_sum_ext[ACC_W-1:0];
`ifdef ADDER_RESULT_ACCUM_SATURATE_EN
    if (w_carry) begin
      w_acc_next = {ACC_W{1'b1}};
    end
`else
    w_acc_next = w_sum_ext[ACC_W-1:0];
`endif
  end

  // clear wins over the input beat, so a beat presented with clear is dropped.
  assign w_ovf_next = r_ovf | w_carry;
  assign w_accept   = in_valid & r_in_ready & (r_state == S_ACCUM) & ~clear;
  assign w_last     = (r_cnt == CNT_W'(COUNT_MAX - 1));

  // Block FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_ACCUM;
      r_acc          <= '0;
      r_cnt          <= '0;
      r_ovf          <= 1'b0;
      r_in_ready     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_total    <= '0;
      r_out_count    <= '0;
      r_out_overflow <= 1'b0;
    end else if (clear) begin
      r_state        <= S_ACCUM;
      r_acc          <= '0;
      r_cnt          <= '0;
      r_ovf          <= 1'b0;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_total    <= '0;
      r_out_count    <= '0;
      r_out_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= w_ovf_next;
            if (w_last) begin
              r_out_total    <= w_acc_next;
              r_out_count    <= CNT_W'(COUNT_MAX);
              r_out_overflow <= w_ovf_next;
              r_out_valid    <= 1'b1;
              r_in_ready     <= 1'b0;
              r_state        <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_ACCUM;
          end
        end
        default: begin
          r_state <= S_ACCUM;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_total    = r_out_total;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_overflow;

endmodule

// File: tb/tb_adder_result_accum.sv
// tb/tb_adder_result_accum.sv - directed table-driven bench for adder_result_accum
module tb_adder_result_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance a: default widths, COUNT_MAX=4
  logic        a_clear, a_in_valid, a_in_ready, a_in_cout, a_out_valid, a_out_ready, a_out_overflow;
  logic [16:0] a_in_sum;
  logic [31:0] a_out_total;
  logic [2:0]  a_out_count;

  // Instance b: ACC_W=18, COUNT_MAX=2
  logic        b_clear, b_in_valid, b_in_ready, b_in_cout, b_out_valid, b_out_ready, b_out_overflow;
  logic [16:0] b_in_sum;
  logic [17:0] b_out_total;
  logic [1:0]  b_out_count;

  // Instance c: COUNT_MAX=1
  logic        c_clear, c_in_valid, c_in_ready, c_in_cout, c_out_valid, c_out_ready, c_out_overflow;
  logic [16:0] c_in_sum;
  logic [31:0] c_out_total;
  logic [0:0]  c_out_count;

  adder_result_accum #(.IN_W(17), .ACC_W(32), .COUNT_MAX(4)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_cout(a_in_cout), .in_sum(a_in_sum), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_total(a_out_total), .out_count(a_out_count), .out_overflow(a_out_overflow));

  adder_result_accum #(.IN_W(17), .ACC_W(18), .COUNT_MAX(2)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_cout(b_in_cout), .in_sum(b_in_sum), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_total(b_out_total), .out_count(b_out_count), .out_overflow(b_out_overflow));

  adder_result_accum #(.IN_W(17), .ACC_W(32), .COUNT_MAX(1)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(c_clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_cout(c_in_cout), .in_sum(c_in_sum), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_total(c_out_total), .out_count(c_out_count), .out_overflow(c_out_overflow));

  int n_checks = 0;
  int n_fail   = 0;
  int a_hs     = 0;

  always @(posedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) a_hs <= a_hs + 1;
  end

  typedef struct packed {
    logic [3:0][17:0] ops;
    logic [31:0]      total;
  } vec_a_t;

  typedef struct packed {
    logic [1:0][17:0] ops;
    logic [17:0]      total;
    logic             ovf;
  } vec_b_t;

`ifdef ADDER_RESULT_ACCUM_SATURATE_EN
  localparam logic [17:0] EXP_B0 = 18'h3FFFF;
  localparam logic [17:0] EXP_B2 = 18'h3FFFF;
`else
  localparam logic [17:0] EXP_B0 = 18'h00001;
  localparam logic [17:0] EXP_B2 = 18'h3FFFE;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic beat_a(input logic [17:0] op);
    int n = 0;
    @(negedge clk);
    a_in_valid = 1'b1;
    {a_in_cout, a_in_sum} = op;
    while (!a_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_ready_wait", a_in_ready, 1);
    @(posedge clk);
  endtask

  task automatic beat_b(input logic [17:0] op);
    int n = 0;
    @(negedge clk);
    b_in_valid = 1'b1;
    {b_in_cout, b_in_sum} = op;
    while (!b_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_ready_wait", b_in_ready, 1);
    @(posedge clk);
  endtask

  task automatic beat_c(input logic [17:0] op);
    int n = 0;
    @(negedge clk);
    c_in_valid = 1'b1;
    {c_in_cout, c_in_sum} = op;
    while (!c_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("c_ready_wait", c_in_ready, 1);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_a_t va[4];
    vec_b_t vb[4];
    int hs0;
    logic [17:0] c_ops[2];

    va[0].ops = {18'h20000, 18'h00001, 18'h3FFFF, 18'h0FFFF}; va[0].total = 32'h0006FFFF;
    va[1].ops = {18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF}; va[1].total = 32'h000FFFFC;
    va[2].ops = {18'h00000, 18'h00000, 18'h00000, 18'h00000}; va[2].total = 32'h00000000;
    va[3].ops = {18'h00004, 18'h00003, 18'h00002, 18'h00001}; va[3].total = 32'h0000000A;

    vb[0].ops = {18'h00002, 18'h3FFFF}; vb[0].total = EXP_B0;   vb[0].ovf = 1'b1;
    vb[1].ops = {18'h20000, 18'h1FFFF}; vb[1].total = 18'h3FFFF; vb[1].ovf = 1'b0;
    vb[2].ops = {18'h3FFFF, 18'h3FFFF}; vb[2].total = EXP_B2;   vb[2].ovf = 1'b1;
    vb[3].ops = {18'h00001, 18'h00001}; vb[3].total = 18'h00002; vb[3].ovf = 1'b0;

    c_ops[0] = 18'h00005;
    c_ops[1] = 18'h3FFFF;

    rst_n = 1'b0;
    a_clear = 0; a_in_valid = 1; a_in_cout = 0; a_in_sum = 17'h1; a_out_ready = 1;
    b_clear = 0; b_in_valid = 0; b_in_cout = 0; b_in_sum = '0;   b_out_ready = 1;
    c_clear = 0; c_in_valid = 0; c_in_cout = 0; c_in_sum = '0;   c_out_ready = 1;

    // Reset state with in_valid driven high
    repeat (3) @(negedge clk);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_total", a_out_total, 0);
    chk("rst_out_count", a_out_count, 0);
    chk("rst_out_overflow", a_out_overflow, 0);
    rst_n = 1'b1;
    chk("rel_in_ready_before_edge", a_in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_after_edge", a_in_ready, 1);
    a_in_valid = 1'b0;

    // Table-driven blocks on instance a, out_ready held high
    hs0 = a_hs;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) beat_a(va[i].ops[j]);
      @(negedge clk);
      a_in_valid = 1'b0;
      chk($sformatf("a_blk%0d_valid", i), a_out_valid, 1);
      chk($sformatf("a_blk%0d_total", i), a_out_total, va[i].total);
      chk($sformatf("a_blk%0d_count", i), a_out_count, 4);
      chk($sformatf("a_blk%0d_ovf", i), a_out_overflow, 0);
      @(negedge clk);
      chk($sformatf("a_blk%0d_valid_drop", i), a_out_valid, 0);
      chk($sformatf("a_blk%0d_ready_back", i), a_in_ready, 1);
    end
    chk("a_handshake_count", a_hs - hs0, 4);

    // Backpressure: held output, in_valid kept high with next block's first beat
    a_out_ready = 1'b0;
    beat_a(18'd10); beat_a(18'd20); beat_a(18'd30); beat_a(18'd40);
    @(negedge clk);
    a_in_valid = 1'b1;
    {a_in_cout, a_in_sum} = 18'd5;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), a_out_valid, 1);
      chk($sformatf("bp%0d_in_ready", k), a_in_ready, 0);
      chk($sformatf("bp%0d_total", k), a_out_total, 100);
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", a_out_valid, 0);
    chk("bp_ready_back", a_in_ready, 1);
    @(posedge clk);
    beat_a(18'd6); beat_a(18'd7); beat_a(18'd8);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("bp_next_valid", a_out_valid, 1);
    chk("bp_next_total", a_out_total, 26);
    @(negedge clk);

    // Clear mid-block drops the concurrent beat
    beat_a(18'd100); beat_a(18'd200);
    @(negedge clk);
    a_clear = 1'b1;
    a_in_valid = 1'b1;
    {a_in_cout, a_in_sum} = 18'd7;
    @(negedge clk);
    a_clear = 1'b0;
    a_in_valid = 1'b0;
    chk("clr_valid", a_out_valid, 0);
    chk("clr_in_ready", a_in_ready, 1);
    for (int k = 0; k < 4; k++) beat_a(18'd1);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("clr_next_valid", a_out_valid, 1);
    chk("clr_next_total", a_out_total, 4);
    chk("clr_next_count", a_out_count, 4);
    @(negedge clk);

    // Clear while holding discards the pending output
    a_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) beat_a(18'd9);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("clrh_valid", a_out_valid, 1);
    chk("clrh_total", a_out_total, 36);
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    chk("clrh_valid_drop", a_out_valid, 0);
    chk("clrh_total_zero", a_out_total, 0);
    chk("clrh_count_zero", a_out_count, 0);
    chk("clrh_in_ready", a_in_ready, 1);
    a_out_ready = 1'b1;

    // Overflow blocks on the narrow instance
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 2; j++) beat_b(vb[i].ops[j]);
      @(negedge clk);
      b_in_valid = 1'b0;
      chk($sformatf("b_blk%0d_valid", i), b_out_valid, 1);
      chk($sformatf("b_blk%0d_total", i), b_out_total, vb[i].total);
      chk($sformatf("b_blk%0d_count", i), b_out_count, 2);
      chk($sformatf("b_blk%0d_ovf", i), b_out_overflow, vb[i].ovf);
      @(negedge clk);
      chk($sformatf("b_blk%0d_valid_drop", i), b_out_valid, 0);
    end

    // COUNT_MAX=1: each beat completes a block
    for (int i = 0; i < 2; i++) begin
      beat_c(c_ops[i]);
      @(negedge clk);
      c_in_valid = 1'b0;
      chk($sformatf("c%0d_valid", i), c_out_valid, 1);
      chk($sformatf("c%0d_total", i), c_out_total, {14'd0, c_ops[i]});
      chk($sformatf("c%0d_count", i), c_out_count, 1);
      @(negedge clk);
      chk($sformatf("c%0d_valid_drop", i), c_out_valid, 0);
    end

    // Asynchronous reset while holding
    a_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) beat_a(18'd3);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("ar_valid", a_out_valid, 1);
    chk("ar_total", a_out_total, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", a_out_valid, 0);
    chk("ar_total_zero", a_out_total, 0);
    chk("ar_count_zero", a_out_count, 0);
    chk("ar_ovf_zero", a_out_overflow, 0);
    chk("ar_in_ready_zero", a_in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("ar_rel_in_ready", a_in_ready, 1);
    chk("ar_rel_valid", a_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
